// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: opcodes, reset PC, FSM states, buffer entry, immediates.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package instr_fetch_unit_pkg;

  localparam logic [6:0]  OPC_JAL          = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_IDLE = 2'd2
  } fetch_state_t;

  // One buffered fetch result: 65 bits {pc, instr, pred}.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } fetch_entry_t;

  function automatic logic [31:0] j_imm(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] b_imm(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_skid_fifo.sv
// Circular buffer of fetch_entry_t with push/pop/flush and occupancy count.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; caller must not push when full unless also popping.
// Ports: clk, rst (async high), flush, push/push_dat, pop, head_dat, empty, count.
module fetch_skid_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_dat,
  input  logic               pop,
  output fetch_entry_t       head_dat,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  // Depth is a power of two, so the pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed when count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues instruction memory reads, buffers {pc, instr, pred} for decode.
// Latency: request in cycle N appears on if_* in N+1 (landing word bypasses an empty buffer).
// Backpressure: if_ready=0 holds the head; issue stops once buffered + in-flight reaches FIFO_DEPTH.
// Ports: clk, rst (async high), fetch_en, redirect_valid/redirect_pc, mem_addr/mem_renable/mem_rdata,
//        mem_addrpred/mem_rdata_pred, if_valid/if_ready/if_instr/if_pc/if_pred_taken.
// Build option: define FETCH_PREDICT_EN to predecode JAL and backward branches for taken prediction.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  output logic        mem_renable,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addrpred,
  input  logic [31:0] mem_rdata_pred,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_pred_taken
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          inflight_pred_q, inflight_pred_d;

  fetch_entry_t     fifo_head, landing, head;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             head_valid, deq, push, pop, issue;
  logic [OCC_W-1:0] occ;
  logic [31:0]      next_pc;
  logic             pred_taken;

  logic unused_rpc_lsb;
  assign unused_rpc_lsb = ^redirect_pc[1:0];

  // Predecode of the word being requested this cycle.
`ifdef FETCH_PREDICT_EN
  assign mem_addrpred = pc_q;
  always_comb begin
    next_pc    = pc_q + 32'd4;
    pred_taken = 1'b0;
    if (mem_rdata_pred[6:0] == OPC_JAL) begin
      next_pc    = pc_q + j_imm(mem_rdata_pred);
      pred_taken = 1'b1;
    end else if (mem_rdata_pred[6:0] == OPC_BRANCH && mem_rdata_pred[31]) begin
      next_pc    = pc_q + b_imm(mem_rdata_pred);
      pred_taken = 1'b1;
    end
  end
`else
  logic unused_pred_word;
  assign unused_pred_word = ^mem_rdata_pred;
  assign mem_addrpred     = 32'h0;
  assign next_pc          = pc_q + 32'd4;
  assign pred_taken       = 1'b0;
`endif

  // The returning word is presented directly when the buffer is empty,
  // giving one-cycle request-to-valid latency.
  assign landing    = {inflight_pc_q, mem_rdata, inflight_pred_q};
  assign head_valid = !fifo_empty || inflight_q;
  assign head       = fifo_empty ? landing : fifo_head;
  assign deq        = head_valid && if_ready;

  // A redirect makes the landing word stale; a bypassed word consumed by decode is not stored.
  assign push = inflight_q && !redirect_valid && !(fifo_empty && deq);
  assign pop  = deq && !fifo_empty && !redirect_valid;

  // Space check counts the word still in flight, less the one leaving this cycle.
  assign occ   = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(deq);
  assign issue = (state_q == ST_RUN) && fetch_en && !redirect_valid &&
                 (occ < OCC_W'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (!fetch_en) state_d = ST_IDLE;
      ST_IDLE: if (fetch_en)  state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    pc_d            = pc_q;
    inflight_d      = issue;
    inflight_pc_d   = inflight_pc_q;
    inflight_pred_d = inflight_pred_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (issue) begin
      pc_d            = next_pc;
      inflight_pc_d   = pc_q;
      inflight_pred_d = pred_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_BOOT;
      pc_q            <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_pc_q   <= 32'h0;
      inflight_pred_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      inflight_q      <= inflight_d;
      inflight_pc_q   <= inflight_pc_d;
      inflight_pred_q <= inflight_pred_d;
    end
  end

  fetch_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (push),
    .push_dat (landing),
    .pop      (pop),
    .head_dat (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign mem_addr      = pc_q;
  assign mem_renable   = issue;
  assign if_valid      = head_valid;
  assign if_pc         = head_valid ? head.pc    : 32'h0;
  assign if_instr      = head_valid ? head.instr : 32'h0;
  assign if_pred_taken = head_valid && head.pred;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr;
  logic        mem_renable;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] mem_addrpred;
  logic [31:0] mem_rdata_pred;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_pred_taken;

  int pass_cnt = 0;
  int total_cnt = 0;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_addr       (mem_addr),
    .mem_renable    (mem_renable),
    .mem_rdata      (mem_rdata),
    .mem_addrpred   (mem_addrpred),
    .mem_rdata_pred (mem_rdata_pred),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken)
  );

  always #5 clk = ~clk;

  // Memory image: a few control-flow words at 0x408/0x418/0x420, elsewhere a
  // tagged word whose opcode bits end in 00 so it never decodes as JAL/branch.
  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0000_0408: return 32'h0100_006F;  // JAL x0, +16
      32'h0000_0418: return 32'h0000_0463;  // BEQ x0,x0,+8 (forward)
      32'h0000_0420: return 32'hFE00_0CE3;  // BEQ x0,x0,-8 (backward)
      default:       return {8'hA5, a[23:0]};
    endcase
  endfunction

  always @(posedge clk) if (mem_renable) mem_rdata <= word(mem_addr);
  assign mem_rdata_pred = word(mem_addrpred);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    int fe, rdy, rv, rpc;
    int ren, addr, v, pc;
  } vec_t;

  vec_t vec [25];

  task automatic run_stream(input logic [31:0] start, input logic [31:0] ea [8], input logic ep [8]);
    redirect_valid = 1'b1;
    redirect_pc    = start;
    #1;
    chk("stream redirect ren", 32'(mem_renable), 32'h0);
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("stream %0d ren", k), 32'(mem_renable), 32'h1);
      chk($sformatf("stream %0d addr", k), mem_addr, ea[k]);
`ifdef FETCH_PREDICT_EN
      chk($sformatf("stream %0d addrpred", k), mem_addrpred, ea[k]);
`else
      chk($sformatf("stream %0d addrpred", k), mem_addrpred, 32'h0);
`endif
      if (k == 0) begin
        chk("stream 0 valid", 32'(if_valid), 32'h0);
      end else begin
        chk($sformatf("stream %0d valid", k), 32'(if_valid), 32'h1);
        chk($sformatf("stream %0d pc", k), if_pc, ea[k-1]);
        chk($sformatf("stream %0d instr", k), if_instr, word(ea[k-1]));
        chk($sformatf("stream %0d pred", k), 32'(if_pred_taken), 32'(ep[k-1]));
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ea [8];
    logic        ep [8];

    // Cycle-by-cycle vectors from reset release: {fetch_en, if_ready, redirect, target | renable, addr, valid, pc}
    vec[0]  = '{1, 1, 0, 0,       0, 'h000, 0, 'h000};  // BOOT
    vec[1]  = '{1, 1, 0, 0,       1, 'h000, 0, 'h000};  // first request
    vec[2]  = '{1, 1, 0, 0,       1, 'h004, 1, 'h000};  // first valid
    vec[3]  = '{1, 1, 0, 0,       1, 'h008, 1, 'h004};
    vec[4]  = '{1, 1, 0, 0,       1, 'h00C, 1, 'h008};
    vec[5]  = '{1, 0, 0, 0,       1, 'h010, 1, 'h00C};  // stall begins
    vec[6]  = '{1, 0, 0, 0,       0, 'h014, 1, 'h00C};  // 1 buffered + 1 in flight
    vec[7]  = '{1, 0, 0, 0,       0, 'h014, 1, 'h00C};  // buffer full
    vec[8]  = '{1, 0, 0, 0,       0, 'h014, 1, 'h00C};
    vec[9]  = '{1, 0, 0, 0,       0, 'h014, 1, 'h00C};
    vec[10] = '{1, 1, 0, 0,       1, 'h014, 1, 'h00C};  // release
    vec[11] = '{1, 1, 0, 0,       1, 'h018, 1, 'h010};
    vec[12] = '{1, 1, 0, 0,       1, 'h01C, 1, 'h014};
    vec[13] = '{1, 1, 0, 0,       1, 'h020, 1, 'h018};
    vec[14] = '{1, 0, 1, 'h100,   0, 'h024, 1, 'h01C};  // redirect: 1 buffered, 0x20 in flight
    vec[15] = '{1, 1, 0, 0,       1, 'h100, 0, 'h000};
    vec[16] = '{1, 1, 0, 0,       1, 'h104, 1, 'h100};
    vec[17] = '{1, 1, 0, 0,       1, 'h108, 1, 'h104};
    vec[18] = '{0, 1, 0, 0,       0, 'h10C, 1, 'h108};  // fetch off: in-flight still lands
    vec[19] = '{0, 1, 0, 0,       0, 'h10C, 0, 'h000};
    vec[20] = '{0, 1, 1, 'h203,   0, 'h10C, 0, 'h000};  // redirect while idle, low bits dropped
    vec[21] = '{1, 1, 0, 0,       0, 'h200, 0, 'h000};  // still IDLE this cycle
    vec[22] = '{1, 1, 0, 0,       1, 'h200, 0, 'h000};
    vec[23] = '{1, 1, 0, 0,       1, 'h204, 1, 'h200};
    vec[24] = '{1, 1, 0, 0,       1, 'h208, 1, 'h204};

    rst = 1'b1;
    fetch_en = 1'b1;
    if_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("reset valid", 32'(if_valid), 32'h0);
    chk("reset renable", 32'(mem_renable), 32'h0);
    chk("reset if_pc", if_pc, 32'h0);
    chk("reset if_instr", if_instr, 32'h0);
    chk("reset pred", 32'(if_pred_taken), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      fetch_en       = (vec[i].fe != 0);
      if_ready       = (vec[i].rdy != 0);
      redirect_valid = (vec[i].rv != 0);
      redirect_pc    = 32'(vec[i].rpc);
      #1;
      chk($sformatf("row%0d ren", i), 32'(mem_renable), 32'(vec[i].ren));
      chk($sformatf("row%0d addr", i), mem_addr, 32'(vec[i].addr));
      chk($sformatf("row%0d valid", i), 32'(if_valid), 32'(vec[i].v));
      chk($sformatf("row%0d pc", i), if_pc, 32'(vec[i].pc));
      chk($sformatf("row%0d instr", i), if_instr,
          (vec[i].v != 0) ? word(32'(vec[i].pc)) : 32'h0);
      chk($sformatf("row%0d pred", i), 32'(if_pred_taken), 32'h0);
      tick();
    end
    redirect_valid = 1'b0;

    // Reset asserted mid-stream: outputs drop without waiting for a clock.
    #1;
    chk("midrst pre valid", 32'(if_valid), 32'h1);
    chk("midrst pre pc", if_pc, 32'h208);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst valid", 32'(if_valid), 32'h0);
    chk("midrst renable", 32'(mem_renable), 32'h0);
    chk("midrst if_pc", if_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rerst boot ren", 32'(mem_renable), 32'h0);
    tick();
    #1;
    chk("rerst ren", 32'(mem_renable), 32'h1);
    chk("rerst addr", mem_addr, 32'h0);
    tick();
    #1;
    chk("rerst valid", 32'(if_valid), 32'h1);
    chk("rerst pc", if_pc, 32'h0);
    chk("rerst addr2", mem_addr, 32'h4);
    tick();

    // Control-flow region: JAL at 0x408, forward BEQ at 0x418, backward BEQ at 0x420.
`ifdef FETCH_PREDICT_EN
    ea = '{32'h400, 32'h404, 32'h408, 32'h418, 32'h41C, 32'h420, 32'h418, 32'h41C};
    ep = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    ea = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h410, 32'h414, 32'h418, 32'h41C};
    ep = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    run_stream(32'h400, ea, ep);

    // PC wraps modulo 2^32.
    ea = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    ep = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_stream(32'hFFFF_FFF8, ea, ep);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
